// File: rtl/mc_sequencer_if.sv
// Control bundle between the multicycle sequencer and the datapath it steers.
// The sequencer holds the master modport; the datapath side holds the slave modport.
interface mc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7;
  logic             zero;
  logic             sign_flag;
  logic             mem_ready;

  logic             PCWrite;
  logic             IRWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ImmSrc;
  logic [2:0]       ALUControl;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct3, funct7, zero, sign_flag, mem_ready,
    output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
    output retire, illegal, instret
  );

  modport slave (
    output op, funct3, funct7, zero, sign_flag, mem_ready,
    input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
    input  retire, illegal, instret
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle RV32 control sequencer: one instruction walks FETCH..writeback,
// with datapath controls decoded from the current state and instruction fields.
module mc_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mc_sequencer_if.master bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB,
    MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] instret_q;

  logic       pcw, irw, adr, memw, regw, ret, ill;
  logic [1:0] rsrc, srca, srcb, aluop;

  function automatic logic [2:0] alu_decode(input logic [1:0] aluop_i,
                                            input logic [2:0] f3,
                                            input logic       op5,
                                            input logic       f7);
    logic [2:0] ctl;
    ctl = 3'b000;
    case (aluop_i)
      2'b01: ctl = 3'b010;
      2'b10: begin
        case (f3)
          3'b000:                                    ctl = (op5 && f7) ? 3'b010 : 3'b000;
          3'b001, 3'b100, 3'b101, 3'b110, 3'b111:    ctl = f3;
          default:                                   ctl = 3'b000;
        endcase
      end
      default: ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       z,
                                        input logic       s);
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = ~z;
      3'b100:  t = s;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] imm_decode(input logic [6:0] opc);
    logic [1:0] imm;
    case (opc)
      OP_SW:   imm = 2'b01;
      OP_BR:   imm = 2'b10;
      default: imm = 2'b00;
    endcase
    return imm;
  endfunction

  // Per-state control decode; every output defaults to 0 and is raised only where it applies.
  always_comb begin
    next_state = state;
    pcw   = 1'b0;
    irw   = 1'b0;
    adr   = 1'b0;
    memw  = 1'b0;
    regw  = 1'b0;
    ret   = 1'b0;
    ill   = 1'b0;
    rsrc  = 2'b00;
    srca  = 2'b00;
    srcb  = 2'b00;
    aluop = 2'b00;
    case (state)
      FETCH: begin
        srcb = 2'b10;
        rsrc = 2'b10;
        pcw  = bus.mem_ready;
        irw  = bus.mem_ready;
        if (bus.mem_ready) next_state = DECODE;
      end
      DECODE: begin
        srca = 2'b01;
        srcb = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_BR:        next_state = BRANCH;
          default: begin
            ill        = 1'b1;
            ret        = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        srca       = 2'b10;
        srcb       = 2'b01;
        next_state = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr = 1'b1;
        if (bus.mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        rsrc       = 2'b01;
        regw       = 1'b1;
        ret        = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        adr  = 1'b1;
        memw = 1'b1;
        if (bus.mem_ready) begin
          ret        = 1'b1;
          next_state = FETCH;
        end
      end
      EXECR: begin
        srca       = 2'b10;
        aluop      = 2'b10;
        next_state = ALUWB;
      end
      EXECI: begin
        srca       = 2'b10;
        srcb       = 2'b01;
        aluop      = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: begin
        regw       = 1'b1;
        ret        = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        srca       = 2'b10;
        aluop      = 2'b01;
        pcw        = branch_taken(bus.funct3, bus.zero, bus.sign_flag);
        ret        = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      instret_q <= '0;
    end else begin
      state <= next_state;
      if (ret) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Write enables and pulses are masked by rst directly so they drop the moment reset asserts.
  assign bus.PCWrite    = pcw  & ~rst;
  assign bus.IRWrite    = irw  & ~rst;
  assign bus.MemWrite   = memw & ~rst;
  assign bus.RegWrite   = regw & ~rst;
  assign bus.retire     = ret  & ~rst;
  assign bus.illegal    = ill  & ~rst;
  assign bus.AdrSrc     = adr;
  assign bus.ResultSrc  = rsrc;
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ImmSrc     = imm_decode(bus.op);
  assign bus.ALUControl = alu_decode(aluop, bus.funct3, bus.op[5], bus.funct7);
  assign bus.instret    = instret_q;

endmodule
